// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory.
// Round-robin on ties, alignment/range faults answered without touching memory.
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  output logic              if_ack,
  output logic              d_ack,
  output logic [31:0]       if_rdata,
  output logic [31:0]       d_rdata,
  output logic              if_err,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        gnt_d;
  logic        we_lat;
  logic        last_d;
  logic [2:0]  wait_cnt;

  logic        pick_d;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [31:0] sel_wdata;
  logic        sel_fault;

  // last_d = 0 means fetch was granted last, so data wins the next tie.
  always_comb begin
    pick_d    = d_req && (!if_req || !last_d);
    sel_addr  = pick_d ? d_addr : if_addr;
    sel_we    = pick_d && d_we;
    sel_wdata = pick_d ? d_wdata : 32'h0;
    sel_fault = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      gnt_d     <= 1'b0;
      we_lat    <= 1'b0;
      last_d    <= 1'b0;
      wait_cnt  <= 3'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_err   <= 1'b0;
      d_err    <= 1'b0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            gnt_d  <= pick_d;
            last_d <= pick_d;
            we_lat <= sel_we;
            busy   <= 1'b1;
            if (sel_fault) begin
              state <= RESP;
              if (pick_d) begin
                d_ack <= 1'b1;
                d_err <= 1'b1;
              end else begin
                if_ack <= 1'b1;
                if_err <= 1'b1;
              end
            end else begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr[ADDR_W+1:2];
              mem_wdata <= sel_wdata;
            end
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= 3'(MEM_LAT);
        end
        WAIT: begin
          // Memory word is valid during the last WAIT cycle; capture it at its end.
          if (wait_cnt <= 3'd1) begin
            wait_cnt <= 3'd0;
            state    <= RESP;
            if (gnt_d) begin
              d_ack   <= 1'b1;
              d_rdata <= we_lat ? 32'h0 : mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance plus a MEM_LAT=3 instance,
// each backed by a memory model whose read word is visible only in its exact cycle.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  // instance a: MEM_LAT = 1
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, if_err, d_err;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // instance b: MEM_LAT = 3
  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata;
  logic        b_if_ack, b_d_ack, b_if_err, b_d_err;
  logic [31:0] b_if_rdata, b_d_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.ADDR_W(10), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .if_ack(if_ack), .d_ack(d_ack), .if_rdata(if_rdata), .d_rdata(d_rdata),
    .if_err(if_err), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(10), .MEM_LAT(3)) dut_b (
    .clock(clock), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr),
    .d_req(b_d_req), .d_addr(b_d_addr), .d_we(b_d_we), .d_wdata(b_d_wdata),
    .if_ack(b_if_ack), .d_ack(b_d_ack), .if_rdata(b_if_rdata), .d_rdata(b_d_rdata),
    .if_err(b_if_err), .d_err(b_d_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: read word appears exactly LAT cycles after the enable cycle, else 0.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic        va;
  logic [31:0] qa;
  logic [2:0]  vb;
  logic [31:0] qb0, qb1, qb2;

  always @(posedge clock) begin
    if (mem_en && mem_we) mem_a[mem_addr] <= mem_wdata;
    va <= mem_en && !mem_we;
    qa <= mem_a[mem_addr];
  end
  assign mem_rdata = va ? qa : 32'h0;

  always @(posedge clock) begin
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    vb  <= {vb[1:0], b_mem_en && !b_mem_we};
    qb0 <= mem_b[b_mem_addr];
    qb1 <= qb0;
    qb2 <= qb1;
  end
  assign b_mem_rdata = vb[2] ? qb2 : 32'h0;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'hA000_0000 + 32'(i);
      mem_b[i] = 32'hA000_0000 + 32'(i);
    end
    va = 1'b0; vb = 3'b000;
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    b_if_req = 0; b_d_req = 0; b_d_we = 0; b_if_addr = 0; b_d_addr = 0; b_d_wdata = 0;

    // reset state
    step(); step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_acks", {28'h0, if_ack, d_ack, if_err, d_err}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_mem_en", 32'(mem_en), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // single fetch read of 0x10
    if_req = 1; if_addr = 32'h10;
    step();
    chk("f_issue_en", 32'(mem_en), 32'h1);
    chk("f_issue_addr", 32'(mem_addr), 32'h4);
    chk("f_issue_we", 32'(mem_we), 32'h0);
    chk("f_issue_busy", 32'(busy), 32'h1);
    step();
    chk("f_wait_en", 32'(mem_en), 32'h0);
    chk("f_wait_ack", 32'(if_ack), 32'h0);
    step();
    chk("f_ack", 32'(if_ack), 32'h1);
    chk("f_rdata", if_rdata, 32'hA000_0004);
    chk("f_err", 32'(if_err), 32'h0);
    chk("f_d_ack", 32'(d_ack), 32'h0);
    if_req = 0;

    // tie after reset: data write wins, fetch follows
    reset = 1; step(); reset = 0;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h14;
    step();
    chk("tie_en", 32'(mem_en), 32'h1);
    chk("tie_we", 32'(mem_we), 32'h1);
    chk("tie_addr", 32'(mem_addr), 32'h8);
    chk("tie_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(); step();
    chk("tie_d_ack", {30'h0, d_ack, if_ack}, 32'h2);
    chk("tie_d_rdata", d_rdata, 32'h0);
    d_req = 0; d_we = 0;
    step();
    chk("tie_idle_ack", {30'h0, d_ack, if_ack}, 32'h0);
    step();
    chk("tie_f_en", 32'(mem_en), 32'h1);
    chk("tie_f_addr", 32'(mem_addr), 32'h5);
    chk("tie_f_we", 32'(mem_we), 32'h0);
    step(); step();
    chk("tie_f_ack", {30'h0, d_ack, if_ack}, 32'h1);
    chk("tie_f_rdata", if_rdata, 32'hA000_0005);
    if_req = 0;
    step();

    // both held for 8 transactions: D,F,D,F,... one ack every 4 cycles
    d_req = 1; d_we = 0; d_addr = 32'h40; if_req = 1; if_addr = 32'h44;
    for (int c = 1; c <= 31; c++) begin
      step();
      if (c % 4 == 3) begin
        if (((c / 4) % 2) == 0) begin
          chk($sformatf("rr%0d_d_ack", c / 4), {30'h0, d_ack, if_ack}, 32'h2);
          chk($sformatf("rr%0d_d_rdata", c / 4), d_rdata, 32'hA000_0010);
        end else begin
          chk($sformatf("rr%0d_f_ack", c / 4), {30'h0, d_ack, if_ack}, 32'h1);
          chk($sformatf("rr%0d_f_rdata", c / 4), if_rdata, 32'hA000_0011);
        end
      end else begin
        chk($sformatf("rr_c%0d_noack", c), {30'h0, d_ack, if_ack}, 32'h0);
      end
    end
    d_req = 0; if_req = 0;
    step();

    // faults: misaligned, then out of range
    d_req = 1; d_addr = 32'h2;
    step();
    chk("mis_ack_err", {30'h0, d_ack, d_err}, 32'h3);
    chk("mis_rdata", d_rdata, 32'h0);
    chk("mis_mem_en", 32'(mem_en), 32'h0);
    d_req = 0;
    step();
    chk("mis_after_ack", 32'(d_ack), 32'h0);
    chk("mis_after_en", 32'(mem_en), 32'h0);
    d_req = 1; d_addr = 32'h1000;
    step();
    chk("oor_ack_err", {30'h0, d_ack, d_err}, 32'h3);
    chk("oor_mem_en", 32'(mem_en), 32'h0);
    d_req = 0;
    step();

    // read back the earlier store through the fetch port
    if_req = 1; if_addr = 32'h20;
    step(); step(); step();
    chk("rb_ack", 32'(if_ack), 32'h1);
    chk("rb_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 0;
    step();

    // reset during WAIT aborts; pointer returns to fetch so data wins the next tie
    d_req = 1; d_addr = 32'h40; d_we = 0;
    step(); step();
    reset = 1;
    step();
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_mem_en", 32'(mem_en), 32'h0);
    chk("rw_ack", {30'h0, d_ack, if_ack}, 32'h0);
    reset = 0; if_req = 1; if_addr = 32'h44;
    step();
    chk("rw_tie_addr", 32'(mem_addr), 32'h10);
    chk("rw_tie_en", 32'(mem_en), 32'h1);
    step(); step();
    chk("rw_d_ack", {30'h0, d_ack, if_ack}, 32'h2);
    chk("rw_d_rdata", d_rdata, 32'hA000_0010);
    d_req = 0;
    step(); step();
    chk("rw_f_addr", 32'(mem_addr), 32'h11);
    step(); step();
    chk("rw_f_ack", {30'h0, d_ack, if_ack}, 32'h1);
    chk("rw_f_rdata", if_rdata, 32'hA000_0011);
    if_req = 0;
    step();

    // MEM_LAT = 3 read: ack at T+5
    b_if_req = 1; b_if_addr = 32'h18;
    step();
    chk("l3_en", 32'(b_mem_en), 32'h1);
    chk("l3_addr", 32'(b_mem_addr), 32'h6);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("l3_c%0d_noack", c), 32'(b_if_ack), 32'h0);
    end
    step();
    chk("l3_ack", 32'(b_if_ack), 32'h1);
    chk("l3_rdata", b_if_rdata, 32'hA000_0006);
    b_if_req = 0;
    step();
    chk("l3_idle_busy", 32'(b_busy), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
